// File: rtl/arith_issue_ctrl_if.sv
// Request/response handshake bundle for arith_issue_ctrl.
// master = requester/consumer side, slave = the controller.
interface arith_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [2:0]       req_op;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/arith_issue_ctrl.sv
// Issue controller for the 32-bit arithmetic unit: holds operands, waits a per-class
// latency, returns the 64-bit result with its tag. Optional perf counter: ARITH_PERF_CNT_EN.
module arith_issue_ctrl #(
    parameter int TAG_W   = 4,
    parameter int LAT_INT = 1,
    parameter int LAT_MUL = 2,
    parameter int LAT_FP  = 3
) (
    input  logic        clk,
    input  logic        rst,
    arith_issue_ctrl_if.slave bus,
    output logic [31:0] au_a,
    output logic [31:0] au_b,
    output logic [2:0]  au_op,
    input  logic [63:0] au_out,
`ifdef ARITH_PERF_CNT_EN
    output logic [31:0] perf_ops,
`endif
    output logic        busy
);

    localparam int MAX_LAT = (LAT_INT > LAT_MUL)
                           ? ((LAT_INT > LAT_FP) ? LAT_INT : LAT_FP)
                           : ((LAT_MUL > LAT_FP) ? LAT_MUL : LAT_FP);
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [TAG_W-1:0] tag;
    logic             req_fire;
    logic             rsp_fire;

    function automatic logic [CNT_W-1:0] lat_of(input logic [2:0] op);
        logic [CNT_W-1:0] lat;
        if (!op[2])
            lat = CNT_W'(LAT_INT);
        else if (op == 3'b100)
            lat = CNT_W'(LAT_MUL);
        else
            lat = CNT_W'(LAT_FP);
        return lat;
    endfunction

    // In RESP a new request may only enter on the same edge the response leaves.
    always_comb begin
        bus.req_ready = 1'b0;
        if (!rst) begin
            if (state == IDLE)
                bus.req_ready = 1'b1;
            else if (state == RESP)
                bus.req_ready = bus.rsp_ready;
        end
    end

    assign req_fire = bus.req_valid && bus.req_ready;
    assign rsp_fire = bus.rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            au_a          <= '0;
            au_b          <= '0;
            au_op         <= '0;
            tag           <= '0;
            cnt           <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_tag   <= '0;
            bus.rsp_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        state <= WAIT;
                        busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        bus.rsp_data  <= au_out;
                        bus.rsp_tag   <= tag;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_fire) begin
                        bus.rsp_valid <= 1'b0;
                        if (req_fire) begin
                            state <= WAIT;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Shared operand load for both IDLE and back-to-back RESP acceptance.
            if (req_fire) begin
                au_a  <= bus.req_a;
                au_b  <= bus.req_b;
                au_op <= bus.req_op;
                tag   <= bus.req_tag;
                cnt   <= lat_of(bus.req_op);
            end
        end
    end

`ifdef ARITH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_ops <= '0;
        else if (rsp_fire)
            perf_ops <= perf_ops + 32'd1;
    end
`endif

endmodule
